// File: rtl/axis_traffic_sink_pkg.sv
// Shared types and helpers for the AXI4-Stream traffic sink: back-pressure modes,
// periodic phase encoding and the splitmix64 seed expander.
package axis_traffic_sink_pkg;

  typedef enum logic [1:0] {
    BP_ALWAYS   = 2'd0,
    BP_RANDOM   = 2'd1,
    BP_PERIODIC = 2'd2,
    BP_STALL    = 2'd3
  } bp_mode_e;

  typedef enum logic {
    PH_ON  = 1'b0,
    PH_OFF = 1'b1
  } phase_e;

  localparam int PHASE_W = 16;

  localparam logic [63:0] SM_GAMMA = 64'h9E37_79B9_7F4A_7C15;
  localparam logic [63:0] SM_MUL1  = 64'hBF58_476D_1CE4_E5B9;
  localparam logic [63:0] SM_MUL2  = 64'h94D0_49BB_1331_11EB;

  // Expands a 64-bit seed into well-mixed PRNG state words at elaboration.
  function automatic logic [63:0] splitmix64(input logic [63:0] x);
    logic [63:0] z;
    z = x + SM_GAMMA;
    z = (z ^ (z >> 6'd30)) * SM_MUL1;
    z = (z ^ (z >> 6'd27)) * SM_MUL2;
    return z ^ (z >> 6'd31);
  endfunction

endpackage

// File: rtl/axis_traffic_sink_lane.sv
// One sink channel: config registers, back-pressure generator, counters and, when
// AXIS_TRAFFIC_SINK_DATA_CHECK_EN is defined, the incrementing-data checker.
module axis_traffic_sink_lane
  import axis_traffic_sink_pkg::*;
#(
  parameter int          DWIDTH    = 32,
  parameter int          HAS_KEEP  = 0,
  parameter int          HAS_LAST  = 0,
  parameter int          CNT_WIDTH = 32,
  parameter logic [63:0] LANE_SEED = 64'h0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DWIDTH-1:0]    tdata_i,
  input  logic                 tvalid_i,
  input  logic [DWIDTH/8-1:0]  tkeep_i,
  input  logic                 tlast_i,
  output logic                 tready_o,
  input  logic [1:0]           bp_mode_i,
  input  logic [63:0]          bp_ratio_i,
  input  logic [PHASE_W-1:0]   bp_on_i,
  input  logic [PHASE_W-1:0]   bp_off_i,
  input  logic                 cnt_clr_i,
  output logic [CNT_WIDTH-1:0] beat_cnt_o,
  output logic [CNT_WIDTH-1:0] pkt_cnt_o,
  output logic [15:0]          err_cnt_o,
  output logic                 err_flag_o
);

  localparam int KW = DWIDTH / 8;

  bp_mode_e           mode_q;
  logic [63:0]        ratio_q;
  logic [PHASE_W-1:0] on_q, off_q;
  logic               run_q;
  logic               tready_q, tready_d;
  phase_e             ph_q, ph_d, ph_eff_s;
  logic [PHASE_W-1:0] pcnt_q, pcnt_d, cur_s, len_s;
  logic               per_ready_s;
  logic [63:0]        rnd_s;
  logic               accept_s, last_s;
  logic [CNT_WIDTH-1:0] beat_q, beat_d, pkt_q, pkt_d;

  xoshiro128ss_simple #(.SEED(LANE_SEED)) u_prng (.clk(clk), .rnd_o(rnd_s));

  // run_q holds tready low for one extra cycle after reset release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q  <= BP_ALWAYS;
      ratio_q <= 64'd0;
      on_q    <= '0;
      off_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      mode_q  <= bp_mode_e'(bp_mode_i);
      ratio_q <= bp_ratio_i;
      on_q    <= bp_on_i;
      off_q   <= bp_off_i;
      run_q   <= 1'b1;
    end
  end

  // Zero-length phases are skipped by evaluating the opposite phase in the same cycle.
  always_comb begin
    ph_eff_s    = ph_q;
    cur_s       = pcnt_q;
    len_s       = on_q;
    per_ready_s = 1'b1;
    ph_d        = PH_ON;
    pcnt_d      = '0;
    if (mode_q != BP_PERIODIC || (on_q == '0 && off_q == '0)) begin
      per_ready_s = 1'b1;
    end else begin
      if (ph_q == PH_ON && on_q == '0) begin
        ph_eff_s = PH_OFF;
        cur_s    = '0;
      end else if (ph_q == PH_OFF && off_q == '0) begin
        ph_eff_s = PH_ON;
        cur_s    = '0;
      end else begin
        ph_eff_s = ph_q;
        cur_s    = pcnt_q;
      end
      len_s       = (ph_eff_s == PH_ON) ? on_q : off_q;
      per_ready_s = (ph_eff_s == PH_ON);
      if (({1'b0, cur_s} + 17'd1) >= {1'b0, len_s}) begin
        ph_d   = (ph_eff_s == PH_ON) ? PH_OFF : PH_ON;
        pcnt_d = '0;
      end else begin
        ph_d   = ph_eff_s;
        pcnt_d = cur_s + 16'd1;
      end
    end
  end

  always_comb begin
    tready_d = 1'b0;
    case (mode_q)
      BP_ALWAYS:   tready_d = 1'b1;
      BP_RANDOM:   tready_d = (rnd_s >= ratio_q);
      BP_PERIODIC: tready_d = per_ready_s;
      BP_STALL:    tready_d = 1'b0;
      default:     tready_d = 1'b0;
    endcase
    if (!run_q) begin
      tready_d = 1'b0;
    end else begin
      tready_d = tready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tready_q <= 1'b0;
      ph_q     <= PH_ON;
      pcnt_q   <= '0;
    end else begin
      tready_q <= tready_d;
      ph_q     <= ph_d;
      pcnt_q   <= pcnt_d;
    end
  end

  assign accept_s = tvalid_i & tready_q;
  assign last_s   = (HAS_LAST != 0) ? tlast_i : 1'b1;

  always_comb begin
    beat_d = beat_q;
    pkt_d  = pkt_q;
    if (cnt_clr_i) begin
      beat_d = '0;
      pkt_d  = '0;
    end else if (accept_s) begin
      beat_d = beat_q + CNT_WIDTH'(1);
      pkt_d  = last_s ? (pkt_q + CNT_WIDTH'(1)) : pkt_q;
    end else begin
      beat_d = beat_q;
      pkt_d  = pkt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_q <= '0;
      pkt_q  <= '0;
    end else begin
      beat_q <= beat_d;
      pkt_q  <= pkt_d;
    end
  end

  assign tready_o   = tready_q;
  assign beat_cnt_o = beat_q;
  assign pkt_cnt_o  = pkt_q;

`ifdef AXIS_TRAFFIC_SINK_DATA_CHECK_EN
  logic [DWIDTH-1:0] exp_q, exp_d, mask_s;
  logic              seeded_q, seeded_d, flag_q, flag_d, mism_s;
  logic [15:0]       err_q, err_d;

  always_comb begin
    mask_s = '0;
    for (int b = 0; b < KW; b++) begin
      mask_s[b*8 +: 8] = (HAS_KEEP == 0 || tkeep_i[b]) ? 8'hFF : 8'h00;
    end
    mism_s = |((tdata_i ^ exp_q) & mask_s);
  end

  always_comb begin
    exp_d    = exp_q;
    seeded_d = seeded_q;
    flag_d   = flag_q;
    err_d    = err_q;
    if (cnt_clr_i) begin
      seeded_d = 1'b0;
      flag_d   = 1'b0;
      err_d    = 16'h0000;
    end else if (accept_s) begin
      seeded_d = 1'b1;
      exp_d    = tdata_i + DWIDTH'(1);
      if (seeded_q && mism_s) begin
        flag_d = 1'b1;
        err_d  = (err_q == 16'hFFFF) ? err_q : (err_q + 16'd1);
      end else begin
        flag_d = flag_q;
        err_d  = err_q;
      end
    end else begin
      exp_d = exp_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exp_q    <= '0;
      seeded_q <= 1'b0;
      flag_q   <= 1'b0;
      err_q    <= 16'h0000;
    end else begin
      exp_q    <= exp_d;
      seeded_q <= seeded_d;
      flag_q   <= flag_d;
      err_q    <= err_d;
    end
  end

  assign err_cnt_o  = err_q;
  assign err_flag_o = flag_q;
`else
  logic unused_data_s;
  assign unused_data_s = ^{tdata_i, tkeep_i};
  assign err_cnt_o     = 16'h0000;
  assign err_flag_o    = 1'b0;
`endif

endmodule

// File: rtl/xoshiro128ss_simple.sv
// Free-running xoshiro128** generator giving a 64-bit word per cycle ({** output, + output}).
// State is never reset; an all-zero state (power-up) loads the elaboration-time seed.
module xoshiro128ss_simple
  import axis_traffic_sink_pkg::*;
#(
  parameter logic [63:0] SEED = 64'h0
) (
  input  logic        clk,
  output logic [63:0] rnd_o
);

  localparam logic [63:0] INIT_HI = splitmix64(SEED);
  localparam logic [63:0] INIT_LO = splitmix64(INIT_HI);

  logic [31:0] s0_q, s1_q, s2_q, s3_q;
  logic [31:0] s0_d, s1_d, s2_d, s3_d;
  logic [31:0] s1x5_s, rot_s, ss_s, t_s;

  always_comb begin
    s1x5_s = (s1_q << 5'd2) + s1_q;
    rot_s  = {s1x5_s[24:0], s1x5_s[31:25]};
    ss_s   = (rot_s << 5'd3) + rot_s;
    t_s    = s1_q << 5'd9;
    s0_d   = s0_q;
    s1_d   = s1_q;
    s2_d   = s2_q;
    s3_d   = s3_q;
    if ({s0_q, s1_q, s2_q, s3_q} == 128'd0) begin
      {s0_d, s1_d} = INIT_HI;
      {s2_d, s3_d} = INIT_LO;
    end else begin
      s2_d = s2_q ^ s0_q;
      s3_d = s3_q ^ s1_q;
      s1_d = s1_q ^ s2_d;
      s0_d = s0_q ^ s3_d;
      s2_d = s2_d ^ t_s;
      s3_d = {s3_d[20:0], s3_d[31:21]};
    end
  end

  always_ff @(posedge clk) begin
    s0_q <= s0_d;
    s1_q <= s1_d;
    s2_q <= s2_d;
    s3_q <= s3_d;
  end

  assign rnd_o = {ss_s, s0_q + s3_q};

endmodule

// File: rtl/axis_traffic_sink.sv
// Multi-channel AXI4-Stream traffic sink with programmable back-pressure and counters.
// Optional data checker enabled by defining AXIS_TRAFFIC_SINK_DATA_CHECK_EN.
module axis_traffic_sink
  import axis_traffic_sink_pkg::*;
#(
  parameter int          NUM_CH    = 1,
  parameter int          DWIDTH    = 32,
  parameter int          HAS_KEEP  = 0,
  parameter int          HAS_LAST  = 0,
  parameter int          CNT_WIDTH = 32,
  parameter logic [63:0] SEED      = 64'h0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CH*DWIDTH-1:0]      s_axis_tdata,
  input  logic [NUM_CH-1:0]             s_axis_tvalid,
  input  logic [NUM_CH*DWIDTH/8-1:0]    s_axis_tkeep,
  input  logic [NUM_CH-1:0]             s_axis_tlast,
  output logic [NUM_CH-1:0]             s_axis_tready,
  input  logic [NUM_CH*2-1:0]           bp_mode,
  input  logic [NUM_CH*64-1:0]          bp_ratio_code,
  input  logic [15:0]                   bp_on_cycles,
  input  logic [15:0]                   bp_off_cycles,
  input  logic                          cnt_clr,
  output logic [NUM_CH*CNT_WIDTH-1:0]   beat_cnt,
  output logic [NUM_CH*CNT_WIDTH-1:0]   pkt_cnt,
  output logic [NUM_CH*16-1:0]          err_cnt,
  output logic [NUM_CH-1:0]             err_flag
);

  localparam int KW = DWIDTH / 8;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    axis_traffic_sink_lane #(
      .DWIDTH   (DWIDTH),
      .HAS_KEEP (HAS_KEEP),
      .HAS_LAST (HAS_LAST),
      .CNT_WIDTH(CNT_WIDTH),
      .LANE_SEED(SEED + 64'(i))
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .tdata_i   (s_axis_tdata[i*DWIDTH +: DWIDTH]),
      .tvalid_i  (s_axis_tvalid[i]),
      .tkeep_i   (s_axis_tkeep[i*KW +: KW]),
      .tlast_i   (s_axis_tlast[i]),
      .tready_o  (s_axis_tready[i]),
      .bp_mode_i (bp_mode[i*2 +: 2]),
      .bp_ratio_i(bp_ratio_code[i*64 +: 64]),
      .bp_on_i   (bp_on_cycles),
      .bp_off_i  (bp_off_cycles),
      .cnt_clr_i (cnt_clr),
      .beat_cnt_o(beat_cnt[i*CNT_WIDTH +: CNT_WIDTH]),
      .pkt_cnt_o (pkt_cnt[i*CNT_WIDTH +: CNT_WIDTH]),
      .err_cnt_o (err_cnt[i*16 +: 16]),
      .err_flag_o(err_flag[i])
    );
  end

endmodule
